// File: rtl/ninjakun_sharb.sv
// Two-CPU shared-RAM arbiter with one mailbox per direction (CPU0->CPU1 and CPU1->CPU0).
// Define NINJAKUN_MBX_OVR_EN to build the sticky overrun flags; otherwise OVR0/OVR1 are tied low.
module ninjakun_sharb #(
  parameter logic [15:0] IO_BASE = 16'hA000,
  parameter logic [15:0] SH_BASE = 16'hE000,
  parameter int unsigned SH_AW   = 11,
  parameter int unsigned DW      = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [15:0]      CP0AD,
  input  logic             CP0RD,
  input  logic             CP0WR,
  input  logic [DW-1:0]    CP0DO,
  input  logic [15:0]      CP1AD,
  input  logic             CP1RD,
  input  logic             CP1WR,
  input  logic [DW-1:0]    CP1DO,
  output logic             CS_IN0,
  output logic             CS_IN1,
  output logic             CS_SH0,
  output logic             CS_SH1,
  output logic             WAIT0,
  output logic             WAIT1,
  output logic [SH_AW-1:0] SH_AD,
  output logic             SH_WE,
  output logic [DW-1:0]    SH_DI,
  output logic             SYNWR0,
  output logic             SYNWR1,
  output logic [DW-1:0]    MBX0,
  output logic [DW-1:0]    MBX1,
  output logic             MBF0,
  output logic             MBF1,
  output logic             OVR0,
  output logic             OVR1
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nx;
  logic   r_last;

  logic w_req0;
  logic w_req1;

  // Address decode is purely combinational so the CPUs see chip selects in the same cycle.
  assign CS_IN0 = (CP0AD[15:2] == IO_BASE[15:2]);
  assign CS_IN1 = (CP1AD[15:2] == IO_BASE[15:2]);
  assign CS_SH0 = (CP0AD[15:SH_AW] == SH_BASE[15:SH_AW]);
  assign CS_SH1 = (CP1AD[15:SH_AW] == SH_BASE[15:SH_AW]);

  assign w_req0 = CS_SH0 & (CP0RD | CP0WR);
  assign w_req1 = CS_SH1 & (CP1RD | CP1WR);

  always_comb begin
    // NOTE: default first so every path assigns w_state_nx and no latch is inferred.
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req0 && w_req1) begin
          w_state_nx = r_last ? ST_OWN0 : ST_OWN1;
        end else if (w_req0) begin
          w_state_nx = ST_OWN0;
        end else if (w_req1) begin
          w_state_nx = ST_OWN1;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_OWN0: begin
        if (w_req0) begin
          w_state_nx = ST_OWN0;
        end else if (w_req1) begin
          w_state_nx = ST_OWN1;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_OWN1: begin
        if (w_req1) begin
          w_state_nx = ST_OWN1;
        end else if (w_req0) begin
          w_state_nx = ST_OWN0;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_state <= w_state_nx;
      if (w_state_nx == ST_OWN0) begin
        r_last <= 1'b0;
      end else if (w_state_nx == ST_OWN1) begin
        r_last <= 1'b1;
      end
    end
  end

  assign WAIT0 = w_req0 & (r_state != ST_OWN0);
  assign WAIT1 = w_req1 & (r_state != ST_OWN1);

  // Shared-RAM port follows the owner; CPU0 drives it while nobody owns the bus.
  always_comb begin
    SH_AD = CP0AD[SH_AW-1:0];
    SH_DI = CP0DO;
    if (r_state == ST_OWN1) begin
      SH_AD = CP1AD[SH_AW-1:0];
      SH_DI = CP1DO;
    end
  end

  assign SH_WE = ((r_state == ST_OWN0) & CP0WR & CS_SH0) |
                 ((r_state == ST_OWN1) & CP1WR & CS_SH1);

  logic w_mwr0;
  logic w_mwr1;
  logic w_mrd0;
  logic w_mrd1;
  logic r_mwr0_d;
  logic r_mwr1_d;
  logic r_mrd0_d;
  logic r_mrd1_d;
  logic w_mwr0_rise;
  logic w_mwr1_rise;
  logic w_mrd0_rise;
  logic w_mrd1_rise;

  assign w_mwr0 = CS_IN0 & (CP0AD[1:0] == 2'd2) & CP0WR;
  assign w_mwr1 = CS_IN1 & (CP1AD[1:0] == 2'd2) & CP1WR;
  assign w_mrd0 = CS_IN0 & (CP0AD[1:0] == 2'd3) & CP0RD;
  assign w_mrd1 = CS_IN1 & (CP1AD[1:0] == 2'd3) & CP1RD;

  // Edge detection turns a strobe held over several cycles into a single mailbox event.
  assign w_mwr0_rise = w_mwr0 & ~r_mwr0_d;
  assign w_mwr1_rise = w_mwr1 & ~r_mwr1_d;
  assign w_mrd0_rise = w_mrd0 & ~r_mrd0_d;
  assign w_mrd1_rise = w_mrd1 & ~r_mrd1_d;

  logic          r_synwr0;
  logic          r_synwr1;
  logic [DW-1:0] r_mbx0;
  logic [DW-1:0] r_mbx1;
  logic          r_mbf0;
  logic          r_mbf1;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_mwr0_d <= 1'b0;
      r_mwr1_d <= 1'b0;
      r_mrd0_d <= 1'b0;
      r_mrd1_d <= 1'b0;
      r_synwr0 <= 1'b0;
      r_synwr1 <= 1'b0;
      r_mbx0   <= '0;
      r_mbx1   <= '0;
      r_mbf0   <= 1'b0;
      r_mbf1   <= 1'b0;
    end else begin
      r_mwr0_d <= w_mwr0;
      r_mwr1_d <= w_mwr1;
      r_mrd0_d <= w_mrd0;
      r_mrd1_d <= w_mrd1;
      r_synwr0 <= w_mwr0_rise;
      r_synwr1 <= w_mwr1_rise;
      if (w_mwr0_rise) begin
        r_mbx0 <= CP0DO;
      end
      if (w_mwr1_rise) begin
        r_mbx1 <= CP1DO;
      end
      // A write landing in the same cycle as the reader's acknowledge keeps the mailbox full.
      if (w_mwr0_rise) begin
        r_mbf0 <= 1'b1;
      end else if (w_mrd1_rise) begin
        r_mbf0 <= 1'b0;
      end
      if (w_mwr1_rise) begin
        r_mbf1 <= 1'b1;
      end else if (w_mrd0_rise) begin
        r_mbf1 <= 1'b0;
      end
    end
  end

  assign SYNWR0 = r_synwr0;
  assign SYNWR1 = r_synwr1;
  assign MBX0   = r_mbx0;
  assign MBX1   = r_mbx1;
  assign MBF0   = r_mbf0;
  assign MBF1   = r_mbf1;

`ifdef NINJAKUN_MBX_OVR_EN
  logic r_ovr0;
  logic r_ovr1;

  // Overrun is sticky: a new write while the previous byte is still unread.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_ovr0 <= 1'b0;
      r_ovr1 <= 1'b0;
    end else begin
      if (w_mwr0_rise && r_mbf0) begin
        r_ovr0 <= 1'b1;
      end
      if (w_mwr1_rise && r_mbf1) begin
        r_ovr1 <= 1'b1;
      end
    end
  end

  assign OVR0 = r_ovr0;
  assign OVR1 = r_ovr1;
`else
  assign OVR0 = 1'b0;
  assign OVR1 = 1'b0;
`endif

endmodule

// File: tb/tb_ninjakun_sharb.sv
// Directed bench for ninjakun_sharb: stimulus pushes per-cycle expectations into a
// scoreboard queue, and a negedge monitor pops and compares them against the DUT outputs.
module tb_ninjakun_sharb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cp0_ad = '0;
  logic        cp0_rd = 1'b0;
  logic        cp0_wr = 1'b0;
  logic [7:0]  cp0_do = '0;
  logic [15:0] cp1_ad = '0;
  logic        cp1_rd = 1'b0;
  logic        cp1_wr = 1'b0;
  logic [7:0]  cp1_do = '0;

  logic        cs_in0, cs_in1, cs_sh0, cs_sh1;
  logic        wait0, wait1;
  logic [10:0] sh_ad;
  logic        sh_we;
  logic [7:0]  sh_di;
  logic        synwr0, synwr1;
  logic [7:0]  mbx0, mbx1;
  logic        mbf0, mbf1, ovr0, ovr1;

`ifdef NINJAKUN_MBX_OVR_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  ninjakun_sharb dut (
    .CLK    (clk),
    .RESET  (rst),
    .CP0AD  (cp0_ad),
    .CP0RD  (cp0_rd),
    .CP0WR  (cp0_wr),
    .CP0DO  (cp0_do),
    .CP1AD  (cp1_ad),
    .CP1RD  (cp1_rd),
    .CP1WR  (cp1_wr),
    .CP1DO  (cp1_do),
    .CS_IN0 (cs_in0),
    .CS_IN1 (cs_in1),
    .CS_SH0 (cs_sh0),
    .CS_SH1 (cs_sh1),
    .WAIT0  (wait0),
    .WAIT1  (wait1),
    .SH_AD  (sh_ad),
    .SH_WE  (sh_we),
    .SH_DI  (sh_di),
    .SYNWR0 (synwr0),
    .SYNWR1 (synwr1),
    .MBX0   (mbx0),
    .MBX1   (mbx1),
    .MBF0   (mbf0),
    .MBF1   (mbf1),
    .OVR0   (ovr0),
    .OVR1   (ovr1)
  );

  typedef struct packed {
    logic        cs_in0;
    logic        cs_in1;
    logic        cs_sh0;
    logic        cs_sh1;
    logic        wait0;
    logic        wait1;
    logic        sh_we;
    logic [10:0] sh_ad;
    logic [7:0]  sh_di;
    logic        synwr0;
    logic        synwr1;
    logic [7:0]  mbx0;
    logic [7:0]  mbx1;
    logic        mbf0;
    logic        mbf1;
    logic        ovr0;
    logic        ovr1;
  } obs_t;

  typedef struct {
    string name;
    obs_t  v;
  } exp_t;

  exp_t sb_q[$];
  obs_t e = '0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active clock edge.
  always @(negedge clk) begin : monitor
    obs_t a;
    exp_t x;
    if (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      a = '{cs_in0, cs_in1, cs_sh0, cs_sh1, wait0, wait1, sh_we, sh_ad, sh_di,
            synwr0, synwr1, mbx0, mbx1, mbf0, mbf1, ovr0, ovr1};
      check(x.name, a, x.v);
    end
  end

  // SYNWR pulses last one cycle, so each new cycle starts with both expected low.
  task automatic tick();
    @(posedge clk);
    #1;
    e.synwr0 = 1'b0;
    e.synwr1 = 1'b0;
  endtask

  task automatic d0(input logic rd, input logic wr, input logic [15:0] ad, input logic [7:0] d);
    cp0_rd = rd;
    cp0_wr = wr;
    cp0_ad = ad;
    cp0_do = d;
  endtask

  task automatic d1(input logic rd, input logic wr, input logic [15:0] ad, input logic [7:0] d);
    cp1_rd = rd;
    cp1_wr = wr;
    cp1_ad = ad;
    cp1_do = d;
  endtask

  task automatic bus(input logic ci0, input logic ci1, input logic cs0, input logic cs1,
                     input logic w0, input logic w1, input logic we,
                     input logic [10:0] ad, input logic [7:0] di);
    e.cs_in0 = ci0;
    e.cs_in1 = ci1;
    e.cs_sh0 = cs0;
    e.cs_sh1 = cs1;
    e.wait0  = w0;
    e.wait1  = w1;
    e.sh_we  = we;
    e.sh_ad  = ad;
    e.sh_di  = di;
  endtask

  task automatic push(input string name);
    exp_t x;
    x.name = name;
    x.v    = e;
    sb_q.push_back(x);
  endtask

  task automatic quiet(input string name);
    d0(0, 0, 16'h0000, 8'h00);
    d1(0, 0, 16'h0000, 8'h00);
    bus(0, 0, 0, 0, 0, 0, 0, 11'h000, 8'h00);
    push(name);
  endtask

  initial begin
    // Reset state
    tick(); rst = 1'b1; quiet("reset");
    tick(); rst = 1'b0; quiet("reset_release");

    // Lone CPU0 read of E010: one wait cycle, then ownership
    tick(); d0(1, 0, 16'hE010, 8'h00); bus(0, 0, 1, 0, 1, 0, 0, 11'h010, 8'h00); push("solo_wait");
    tick(); bus(0, 0, 1, 0, 0, 0, 0, 11'h010, 8'h00); push("solo_own0");
    tick(); quiet("solo_drop");
    tick(); quiet("solo_idle");

    // Fresh reset so LAST points at CPU1 again
    tick(); rst = 1'b1; quiet("reset2");
    tick(); rst = 1'b0; quiet("reset2_release");

    // Conflict: CPU0 first, then hand-off to a CPU1 write with no idle cycle
    tick(); d0(1, 0, 16'hE000, 8'h00); d1(0, 1, 16'hE123, 8'h3C);
    bus(0, 0, 1, 1, 1, 1, 0, 11'h000, 8'h00); push("conf_both");
    tick(); bus(0, 0, 1, 1, 0, 1, 0, 11'h000, 8'h00); push("conf_own0");
    tick(); d0(0, 0, 16'h0000, 8'h00); bus(0, 0, 0, 1, 0, 1, 0, 11'h000, 8'h00); push("conf_drop0");
    tick(); bus(0, 0, 0, 1, 0, 0, 1, 11'h123, 8'h3C); push("conf_own1_we");
    tick(); quiet("conf_drop1");
    tick(); quiet("conf_idle");

    // Repeat conflicts alternate: LAST=1 grants CPU0, then LAST=0 grants CPU1
    tick(); d0(1, 0, 16'hE000, 8'h00); d1(1, 0, 16'hE123, 8'h00);
    bus(0, 0, 1, 1, 1, 1, 0, 11'h000, 8'h00); push("alt_both_a");
    tick(); bus(0, 0, 1, 1, 0, 1, 0, 11'h000, 8'h00); push("alt_grant0");
    tick(); quiet("alt_rel_a");
    tick(); quiet("alt_idle_a");
    tick(); d0(1, 0, 16'hE000, 8'h00); d1(1, 0, 16'hE123, 8'h00);
    bus(0, 0, 1, 1, 1, 1, 0, 11'h000, 8'h00); push("alt_both_b");
    tick(); bus(0, 0, 1, 1, 1, 0, 0, 11'h123, 8'h00); push("alt_grant1");
    tick(); quiet("alt_rel_b");
    tick(); quiet("alt_idle_b");

    // CPU0 mailbox write held three cycles, then CPU1 acknowledges via A003
    tick(); d0(0, 1, 16'hA002, 8'h5A); bus(1, 0, 0, 0, 0, 0, 0, 11'h002, 8'h5A); push("mbx_wr");
    tick(); e.synwr0 = 1'b1; e.mbx0 = 8'h5A; e.mbf0 = 1'b1; push("mbx_pulse");
    tick(); push("mbx_hold_nopulse");
    tick(); quiet("mbx_wr_drop");
    tick(); d1(1, 0, 16'hA003, 8'h00); bus(0, 1, 0, 0, 0, 0, 0, 11'h000, 8'h00); push("mbx_rd");
    tick(); e.mbf0 = 1'b0; push("mbx_cleared");
    tick(); quiet("mbx_rd_drop");

    // Write and acknowledge in the same cycle: set wins
    tick(); d0(0, 1, 16'hA002, 8'hA5); d1(1, 0, 16'hA003, 8'h00);
    bus(1, 1, 0, 0, 0, 0, 0, 11'h002, 8'hA5); push("coinc_issue");
    tick(); e.synwr0 = 1'b1; e.mbx0 = 8'hA5; e.mbf0 = 1'b1; push("coinc_set_wins");
    tick(); quiet("coinc_drop");

    // Two CPU1 mailbox writes with no acknowledge in between
    tick(); d1(0, 1, 16'hA002, 8'h11); bus(0, 1, 0, 0, 0, 0, 0, 11'h000, 8'h00); push("ovr_wr1");
    tick(); quiet_keep1: begin
      d1(0, 0, 16'h0000, 8'h00); bus(0, 0, 0, 0, 0, 0, 0, 11'h000, 8'h00);
      e.synwr1 = 1'b1; e.mbx1 = 8'h11; e.mbf1 = 1'b1; push("ovr_pulse1");
    end
    tick(); d1(0, 1, 16'hA002, 8'h22); bus(0, 1, 0, 0, 0, 0, 0, 11'h000, 8'h00); push("ovr_wr2");
    tick(); d1(0, 0, 16'h0000, 8'h00); bus(0, 0, 0, 0, 0, 0, 0, 11'h000, 8'h00);
    e.synwr1 = 1'b1; e.mbx1 = 8'h22; e.ovr1 = OVR_EXP; push("ovr_pulse2");
    tick(); quiet("ovr_idle");
    tick(); d0(1, 0, 16'hA003, 8'h00); bus(1, 0, 0, 0, 0, 0, 0, 11'h003, 8'h00); push("mbf1_rd");
    tick(); e.mbf1 = 1'b0; quiet("mbf1_cleared");

    // Asynchronous reset while CPU1 owns the bus and MBF0 is set
    tick(); d1(1, 0, 16'hE050, 8'h00); bus(0, 0, 0, 1, 0, 1, 0, 11'h000, 8'h00); push("rst_req1");
    tick(); bus(0, 0, 0, 1, 0, 0, 0, 11'h050, 8'h00); push("rst_own1");
    tick(); rst = 1'b1; bus(0, 0, 0, 1, 0, 1, 0, 11'h000, 8'h00);
    e.mbx0 = 8'h00; e.mbx1 = 8'h00; e.mbf0 = 1'b0; e.mbf1 = 1'b0; e.ovr0 = 1'b0; e.ovr1 = 1'b0;
    push("rst_async");
    tick(); rst = 1'b0; push("rst_release_wait");
    tick(); bus(0, 0, 0, 1, 0, 0, 0, 11'h050, 8'h00); push("rst_regrant");
    tick(); quiet("rst_drop");
    tick(); quiet("rst_idle");

    // Window boundaries: A006 is outside the I/O window, E800 outside and E7FF inside shared RAM
    tick(); d0(0, 1, 16'hA006, 8'h77); bus(0, 0, 0, 0, 0, 0, 0, 11'h006, 8'h77); push("bnd_a006");
    tick(); quiet("bnd_a006_nopulse");
    tick(); d1(1, 0, 16'hE800, 8'h00); bus(0, 0, 0, 0, 0, 0, 0, 11'h000, 8'h00); push("bnd_e800");
    tick(); d1(1, 0, 16'hE7FF, 8'h00); bus(0, 0, 0, 1, 0, 1, 0, 11'h000, 8'h00); push("bnd_e7ff_wait");
    tick(); bus(0, 0, 0, 1, 0, 0, 0, 11'h7FF, 8'h00); push("bnd_e7ff_own1");
    tick(); quiet("bnd_drop");
    tick(); quiet("bnd_idle");

    repeat (3) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
